fir_xifu_ctrl: RTL

In-order issue/commit/retire controller for the FIR XIFU pipeline (ID -> EX -> WB -> XIFU regfile). It holds each accepted offloaded instruction in an ordered in-flight queue until commit, then dispatches committed, non-killed instructions to EX. It tracks pending XIFU-regfile writes in a scoreboard to stall RAW/WAW hazards, and retires instructions on WB completion. It sits between the fir_xifu ID decoder and the EX stage.

---
 rtl/fir_xifu_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/fir_xifu_ctrl.sv
// fir_xifu_ctrl: in-order issue/commit/dispatch/retire controller for the
// FIR XIFU pipeline. Accepted instructions wait in an ordered in-flight queue
// until committed, then go to EX in order. A scoreboard of pending XIFU
// register writes stalls RAW/WAW hazards at issue.
// Optional build macro: FIR_XIFU_CTRL_WB_BYPASS_EN -- lets an instruction
// issue in the same cycle its producer retires.
module fir_xifu_ctrl #(
   parameter int  NB_REGS     = 4,
   parameter int  NB_INFLIGHT = 4,
   parameter int  ID_WIDTH    = 4,
   localparam int RIDX_W      = $clog2(NB_REGS),
   localparam int CNT_W       = $clog2(NB_INFLIGHT) + 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                clear_i,
   input  logic                issue_valid_i,
   input  logic                issue_accept_i,
   input  logic [ID_WIDTH-1:0] issue_id_i,
   input  logic [NB_REGS-1:0]  issue_rs_mask_i,
   input  logic                issue_rd_valid_i,
   input  logic [RIDX_W-1:0]   issue_rd_i,
   output logic                issue_ready_o,
   input  logic                commit_valid_i,
   input  logic [ID_WIDTH-1:0] commit_id_i,
   input  logic                commit_kill_i,
   output logic                dispatch_valid_o,
   output logic [ID_WIDTH-1:0] dispatch_id_o,
   input  logic                dispatch_ready_i,
   input  logic                wb_valid_i,
   input  logic [ID_WIDTH-1:0] wb_id_i,
   output logic [CNT_W-1:0]    inflight_o,
   output logic                busy_o,
   output logic                error_o
);

   localparam int PTR_W = CNT_W - 1;

   typedef enum logic {RUN, DRAIN} state_t;

   state_t state_q, state_d;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [CNT_W-1:0] head_q, disp_q, tail_q;
   logic [CNT_W-1:0] head_d, disp_d, tail_d;
   logic [CNT_W-1:0] count, drop_cnt;
   logic [PTR_W-1:0] head_idx, disp_idx, tail_idx;

   // Queue storage: one slot per in-flight instruction.
   logic [ID_WIDTH-1:0]    q_id [NB_INFLIGHT];
   logic [RIDX_W-1:0]      q_rd [NB_INFLIGHT];
   logic [NB_INFLIGHT-1:0] q_rdv, q_cmt, q_kill, q_dsp;

   logic [NB_REGS-1:0] sb_q, sb_d, sb_set, sb_clr, byp_mask, sb_eff;
   logic               err_q, err_d;

   logic full, empty, hazard, accept, new_commit;
   logic disp_avail, do_disp, do_skip, auto_pop, do_pop;
   logic [NB_INFLIGHT-1:0] slot_valid, slot_drop, commit_hit;

   assign head_idx = head_q[PTR_W-1:0];
   assign disp_idx = disp_q[PTR_W-1:0];
   assign tail_idx = tail_q[PTR_W-1:0];
   assign count    = tail_q - head_q;
   assign drop_cnt = tail_q - disp_q;
   assign empty    = (count == '0);
   assign full     = (count == CNT_W'(NB_INFLIGHT));

   // Per-slot occupancy, drain-discard range and commit id match.
   always_comb begin
      slot_valid = '0;
      slot_drop  = '0;
      commit_hit = '0;
      for (int i = 0; i < NB_INFLIGHT; i++) begin
         slot_valid[i] = ({1'b0, PTR_W'(i) - head_idx} < count);
         slot_drop[i]  = ({1'b0, PTR_W'(i) - disp_idx} < drop_cnt);
         commit_hit[i] = commit_valid_i & slot_valid[i] & ~q_cmt[i] &
                         (q_id[i] == commit_id_i);
      end
   end

   // Issue-side hazard check against pending writes.
   always_comb begin
      byp_mask = '0;
`ifdef FIR_XIFU_CTRL_WB_BYPASS_EN
      // The register freed by this cycle's retire does not block issue.
      // Killed entries already dropped their scoreboard bit, so they never
      // unmask anything.
      if (wb_valid_i && !empty && q_rdv[head_idx] && !q_kill[head_idx])
         byp_mask[q_rd[head_idx]] = 1'b1;
`endif
      sb_eff = sb_q & ~byp_mask;
      hazard = (|(issue_rs_mask_i & sb_eff)) |
               (issue_rd_valid_i & sb_eff[issue_rd_i]);
   end

   assign issue_ready_o = (state_q == RUN) & ~rst_i & ~full & ~hazard;
   assign accept        = issue_valid_i & issue_accept_i & issue_ready_o;
   // A commit may target the instruction being pushed this same cycle.
   assign new_commit    = commit_valid_i & (commit_id_i == issue_id_i);

   // Dispatch, kill-skip and pop decisions.
   always_comb begin
      disp_avail       = (state_q == RUN) & (disp_q != tail_q);
      dispatch_valid_o = ~rst_i & disp_avail & q_cmt[disp_idx] &
                         ~q_kill[disp_idx] & ~q_dsp[disp_idx];
      dispatch_id_o    = dispatch_valid_o ? q_id[disp_idx] : '0;
      do_disp          = dispatch_valid_o & dispatch_ready_i;
      do_skip          = disp_avail & q_cmt[disp_idx] & q_kill[disp_idx];
      auto_pop         = ~empty & q_cmt[head_idx] & q_kill[head_idx] &
                         ~q_dsp[head_idx];
      do_pop           = ~empty & (wb_valid_i | auto_pop);
      err_d            = err_q | (wb_valid_i & (empty | ~q_dsp[head_idx] |
                                               (q_id[head_idx] != wb_id_i)));
   end

   // Pointer updates; in DRAIN everything not yet dispatched is dropped.
   always_comb begin
      disp_d = disp_q + CNT_W'(do_disp | do_skip);
      // A popped head that was also the dispatch point drags disp along.
      if (do_pop && (disp_q == head_q))
         disp_d = head_q + CNT_W'(1);
      head_d = head_q + CNT_W'(do_pop);
      if (state_q == DRAIN)
         tail_d = disp_d;
      else
         tail_d = tail_q + CNT_W'(accept);
   end

   // Scoreboard: clears from retire, kill-skip and drain; a set wins.
   always_comb begin
      sb_set = '0;
      sb_clr = '0;
      if (do_pop && q_rdv[head_idx] && !q_kill[head_idx])
         sb_clr[q_rd[head_idx]] = 1'b1;
      if (do_skip && q_rdv[disp_idx])
         sb_clr[q_rd[disp_idx]] = 1'b1;
      if (state_q == DRAIN) begin
         for (int i = 0; i < NB_INFLIGHT; i++)
            if (slot_drop[i] && q_rdv[i])
               sb_clr[q_rd[i]] = 1'b1;
      end
      if (accept && issue_rd_valid_i)
         sb_set[issue_rd_i] = 1'b1;
      sb_d = (sb_q & ~sb_clr) | sb_set;
   end

   // Next-state logic: flush enters DRAIN, an empty queue returns to RUN.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (clear_i) state_d = DRAIN;
         DRAIN:   if (empty)   state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // State register, pointers, scoreboard and queue slot updates.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RUN;
         head_q  <= '0;
         disp_q  <= '0;
         tail_q  <= '0;
         sb_q    <= '0;
         err_q   <= 1'b0;
         q_rdv   <= '0;
         q_cmt   <= '0;
         q_kill  <= '0;
         q_dsp   <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         disp_q  <= disp_d;
         tail_q  <= tail_d;
         sb_q    <= sb_d;
         err_q   <= err_d;
         for (int i = 0; i < NB_INFLIGHT; i++) begin
            if (commit_hit[i]) begin
               q_cmt[i]  <= 1'b1;
               q_kill[i] <= commit_kill_i;
            end
         end
         if (do_disp)
            q_dsp[disp_idx] <= 1'b1;
         // The tail slot is free, so it never collides with a commit hit.
         if (accept) begin
            q_id[tail_idx]   <= issue_id_i;
            q_rd[tail_idx]   <= issue_rd_i;
            q_rdv[tail_idx]  <= issue_rd_valid_i;
            q_cmt[tail_idx]  <= new_commit;
            q_kill[tail_idx] <= new_commit & commit_kill_i;
            q_dsp[tail_idx]  <= 1'b0;
         end
      end
   end

   assign inflight_o = count;
   assign busy_o     = ~empty | (state_q != RUN);
   assign error_o    = err_q;

endmodule
